// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory arbiter controller.
// State encoding and default bus widths.
package mem_ctrl_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, search starts after last_grant.
// Pure combinational; reusable on any shared bus.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last_grant,
  output logic [N-1:0]  gnt,
  output logic [LW-1:0] idx,
  output logic          any
);

  int   j;
  logic found;

  // first requester found walking upward from last_grant+1
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_grant) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = LW'(j);
      end
    end
    any = found;
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// N-client round-robin memory controller, one txn outstanding.
// Optional wait-state abort: MEM_ARB_CTRL_TIMEOUT_EN.
module mem_arb_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic [N_CH-1:0]   I_exec,
  input  logic [N_CH-1:0]   I_write,
  input  logic [N_CH*AW-1:0] I_addr,
  input  logic [N_CH*DW-1:0] I_data,
  output logic [N_CH-1:0]   O_ready,
  output logic [N_CH-1:0]   O_grant,
  output logic [N_CH-1:0]   O_done,
  output logic [N_CH-1:0]   O_data_ready,
  output logic [N_CH-1:0]   O_error,
  output logic [DW-1:0]     O_data,
  input  logic              MEM_ready,
  output logic              MEM_exec,
  output logic              MEM_write,
  output logic [AW-1:0]     MEM_addr,
  output logic [DW-1:0]     MEM_data_out,
  input  logic [DW-1:0]     MEM_data_in,
  input  logic              MEM_data_ready
);

  localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t          state;
  logic [LW-1:0]   last_grant;
  logic [N_CH-1:0] arb_gnt;
  logic [LW-1:0]   arb_idx;
  logic            arb_any;
  logic            wr_cmpl;

  rr_arbiter #(
    .N  (N_CH),
    .LW (LW)
  ) u_arb (
    .req        (I_exec),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  // clients may issue only when idle, memory free, not already asking
  assign O_ready = {N_CH{(state == ST_IDLE) && MEM_ready}} & ~I_exec;

  // write ends once memory is ready again, ignoring the start cycle
  assign wr_cmpl = MEM_ready && !MEM_exec;

`ifdef MEM_ARB_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign O_error    = '0;
`endif

  // controller FSM; all memory and client outputs registered here
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state        <= ST_IDLE;
      last_grant   <= LW'(N_CH - 1);
      MEM_exec     <= 1'b0;
      MEM_write    <= 1'b0;
      MEM_addr     <= '0;
      MEM_data_out <= '0;
      O_data       <= '0;
      O_grant      <= '0;
      O_done       <= '0;
      O_data_ready <= '0;
`ifdef MEM_ARB_CTRL_TIMEOUT_EN
      O_error      <= '0;
      tmo_cnt      <= '0;
`endif
    end else begin
      MEM_exec     <= 1'b0;
      O_grant      <= '0;
      O_done       <= '0;
      O_data_ready <= '0;
`ifdef MEM_ARB_CTRL_TIMEOUT_EN
      O_error      <= '0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (MEM_ready && arb_any) begin
            MEM_write    <= I_write[arb_idx];
            MEM_addr     <= I_addr[arb_idx*AW +: AW];
            MEM_data_out <= I_data[arb_idx*DW +: DW];
            MEM_exec     <= 1'b1;
            O_grant      <= arb_gnt;
            last_grant   <= arb_idx;
`ifdef MEM_ARB_CTRL_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
            state <= I_write[arb_idx] ? ST_WR_WAIT
                                      : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (MEM_data_ready) begin
            O_data                   <= MEM_data_in;
            O_data_ready[last_grant] <= 1'b1;
            O_done[last_grant]       <= 1'b1;
            state                    <= ST_IDLE;
          end
`ifdef MEM_ARB_CTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            O_error[last_grant] <= 1'b1;
            O_done[last_grant]  <= 1'b1;
            state               <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_WR_WAIT: begin
          if (wr_cmpl) begin
            O_done[last_grant] <= 1'b1;
            state              <= ST_IDLE;
          end
`ifdef MEM_ARB_CTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            O_error[last_grant] <= 1'b1;
            O_done[last_grant]  <= 1'b1;
            state               <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl, two channels.
// Memory side is driven by hand from each scenario task.
module tb_mem_arb_ctrl;

  localparam int N_CH = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;

  logic              I_clk = 1'b0;
  logic              I_reset;
  logic [N_CH-1:0]   I_exec;
  logic [N_CH-1:0]   I_write;
  logic [N_CH*AW-1:0] I_addr;
  logic [N_CH*DW-1:0] I_data;
  logic [N_CH-1:0]   O_ready;
  logic [N_CH-1:0]   O_grant;
  logic [N_CH-1:0]   O_done;
  logic [N_CH-1:0]   O_data_ready;
  logic [N_CH-1:0]   O_error;
  logic [DW-1:0]     O_data;
  logic              MEM_ready;
  logic              MEM_exec;
  logic              MEM_write;
  logic [AW-1:0]     MEM_addr;
  logic [DW-1:0]     MEM_data_out;
  logic [DW-1:0]     MEM_data_in;
  logic              MEM_data_ready;

  int vec  = 0;
  int errs = 0;

  always #5 I_clk = ~I_clk;

  mem_arb_ctrl #(
    .N_CH           (N_CH),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .I_clk          (I_clk),
    .I_reset        (I_reset),
    .I_exec         (I_exec),
    .I_write        (I_write),
    .I_addr         (I_addr),
    .I_data         (I_data),
    .O_ready        (O_ready),
    .O_grant        (O_grant),
    .O_done         (O_done),
    .O_data_ready   (O_data_ready),
    .O_error        (O_error),
    .O_data         (O_data),
    .MEM_ready      (MEM_ready),
    .MEM_exec       (MEM_exec),
    .MEM_write      (MEM_write),
    .MEM_addr       (MEM_addr),
    .MEM_data_out   (MEM_data_out),
    .MEM_data_in    (MEM_data_in),
    .MEM_data_ready (MEM_data_ready)
  );

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic test_reset();
    I_reset = 1'b1;
    step();
    step();
    I_reset = 1'b0;
    vec++;
    if (MEM_exec !== 1'b0 || MEM_write !== 1'b0) begin
      errs++;
      $display("FAIL rst_mem_ctl got exec=%b wr=%b want 0 0",
               MEM_exec, MEM_write);
    end
    vec++;
    if (MEM_addr !== 16'h0 || MEM_data_out !== 16'h0 ||
        O_data !== 16'h0) begin
      errs++;
      $display("FAIL rst_data got addr=%h dout=%h odata=%h want 0",
               MEM_addr, MEM_data_out, O_data);
    end
    vec++;
    if (O_grant !== 2'b00 || O_done !== 2'b00 ||
        O_data_ready !== 2'b00 || O_error !== 2'b00) begin
      errs++;
      $display("FAIL rst_pulses got g=%b d=%b dr=%b e=%b want 00",
               O_grant, O_done, O_data_ready, O_error);
    end
    vec++;
    if (O_ready !== 2'b11) begin
      errs++;
      $display("FAIL rst_ready got %b want 11", O_ready);
    end
  endtask

  task automatic test_single_read();
    int extra_exec;
    extra_exec = 0;
    I_addr[0*AW +: AW] = 16'h0040;
    I_write = 2'b00;
    I_exec  = 2'b01;
    step();
    vec++;
    if (O_grant !== 2'b01 || MEM_exec !== 1'b1 ||
        MEM_addr !== 16'h0040 || MEM_write !== 1'b0) begin
      errs++;
      $display("FAIL rd_grant got g=%b ex=%b a=%h w=%b want 01 1 0040 0",
               O_grant, MEM_exec, MEM_addr, MEM_write);
    end
    I_exec = 2'b00;
    step();
    if (MEM_exec !== 1'b0) extra_exec++;
    vec++;
    if (O_ready !== 2'b00) begin
      errs++;
      $display("FAIL rd_busy_ready got %b want 00", O_ready);
    end
    step();
    if (MEM_exec !== 1'b0) extra_exec++;
    MEM_data_in    = 16'hBEEF;
    MEM_data_ready = 1'b1;
    step();
    MEM_data_ready = 1'b0;
    vec++;
    if (O_data_ready !== 2'b01 || O_done !== 2'b01 ||
        O_data !== 16'hBEEF) begin
      errs++;
      $display("FAIL rd_done got dr=%b d=%b data=%h want 01 01 beef",
               O_data_ready, O_done, O_data);
    end
    vec++;
    if (extra_exec != 0 || MEM_exec !== 1'b0) begin
      errs++;
      $display("FAIL rd_exec_pulse got extra=%0d want 0", extra_exec);
    end
    step();
    vec++;
    if (O_done !== 2'b00 || O_data !== 16'hBEEF) begin
      errs++;
      $display("FAIL rd_hold got d=%b data=%h want 00 beef",
               O_done, O_data);
    end
  endtask

  task automatic test_write_ch1();
    int early;
    early = 0;
    I_addr[1*AW +: AW] = 16'h0080;
    I_data[1*DW +: DW] = 16'h1234;
    I_write = 2'b10;
    I_exec  = 2'b10;
    step();
    vec++;
    if (O_grant !== 2'b10 || MEM_write !== 1'b1 ||
        MEM_data_out !== 16'h1234 || MEM_addr !== 16'h0080) begin
      errs++;
      $display("FAIL wr_grant got g=%b w=%b d=%h a=%h want 10 1 1234 0080",
               O_grant, MEM_write, MEM_data_out, MEM_addr);
    end
    I_exec    = 2'b00;
    MEM_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (O_done !== 2'b00) early++;
    end
    MEM_ready = 1'b1;
    vec++;
    if (early != 0) begin
      errs++;
      $display("FAIL wr_early_done got %0d want 0", early);
    end
    step();
    vec++;
    if (O_done !== 2'b10 || O_data_ready !== 2'b00) begin
      errs++;
      $display("FAIL wr_done got d=%b dr=%b want 10 00",
               O_done, O_data_ready);
    end
    I_write = 2'b00;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    I_exec = 2'b11;
    for (int t = 0; t < 4; t++) begin
      int cyc;
      cyc = 0;
      step();
      while (O_grant === 2'b00 && cyc < 10) begin
        step();
        cyc++;
      end
      want = (t % 2 == 0) ? 2'b01 : 2'b10;
      vec++;
      if (O_grant !== want) begin
        errs++;
        $display("FAIL rr_grant%0d got %b want %b", t, O_grant, want);
      end
      MEM_data_in    = 16'hA000 + 16'(t);
      MEM_data_ready = 1'b1;
      step();
      MEM_data_ready = 1'b0;
      vec++;
      if (O_done !== want || O_data !== 16'hA000 + 16'(t)) begin
        errs++;
        $display("FAIL rr_done%0d got d=%b data=%h want %b %h",
                 t, O_done, O_data, want, 16'hA000 + 16'(t));
      end
    end
    I_exec = 2'b00;
    step();
  endtask

  task automatic test_mem_ready_low();
    int bad;
    bad = 0;
    MEM_ready = 1'b0;
    I_exec    = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      if (O_grant !== 2'b00 || MEM_exec !== 1'b0 ||
          O_ready !== 2'b00) bad++;
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL mrl_stall got %0d bad cycles want 0", bad);
    end
    MEM_ready = 1'b1;
    step();
    vec++;
    if (O_grant !== 2'b01 || MEM_exec !== 1'b1) begin
      errs++;
      $display("FAIL mrl_grant got g=%b ex=%b want 01 1",
               O_grant, MEM_exec);
    end
    I_exec         = 2'b00;
    MEM_data_in    = 16'h5A5A;
    MEM_data_ready = 1'b1;
    step();
    MEM_data_ready = 1'b0;
    vec++;
    if (O_done !== 2'b01 || O_data !== 16'h5A5A) begin
      errs++;
      $display("FAIL mrl_done got d=%b data=%h want 01 5a5a",
               O_done, O_data);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    I_addr[1*AW +: AW] = 16'h0123;
    I_exec = 2'b10;
    step();
    vec++;
    if (O_grant !== 2'b10) begin
      errs++;
      $display("FAIL mid_grant got %b want 10", O_grant);
    end
    I_exec = 2'b00;
    step();
    I_reset = 1'b1;
    step();
    I_reset = 1'b0;
    vec++;
    if (MEM_exec !== 1'b0 || MEM_addr !== 16'h0 ||
        MEM_write !== 1'b0 || MEM_data_out !== 16'h0 ||
        O_data !== 16'h0 || O_done !== 2'b00) begin
      errs++;
      $display("FAIL mid_rst got ex=%b a=%h data=%h d=%b want reset",
               MEM_exec, MEM_addr, O_data, O_done);
    end
    MEM_data_in    = 16'hDEAD;
    MEM_data_ready = 1'b1;
    step();
    MEM_data_ready = 1'b0;
    vec++;
    if (O_done !== 2'b00 || O_data_ready !== 2'b00 ||
        O_data !== 16'h0) begin
      errs++;
      $display("FAIL mid_stale got d=%b dr=%b data=%h want 00 00 0",
               O_done, O_data_ready, O_data);
    end
    I_exec = 2'b11;
    step();
    vec++;
    if (O_grant !== 2'b01) begin
      errs++;
      $display("FAIL mid_regrant got %b want 01", O_grant);
    end
    I_exec         = 2'b00;
    MEM_data_in    = 16'h7777;
    MEM_data_ready = 1'b1;
    step();
    MEM_data_ready = 1'b0;
    step();
  endtask

`ifdef MEM_ARB_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    logic [DW-1:0] held;
    held   = O_data;
    cyc    = 0;
    I_exec = 2'b01;
    step();
    I_exec = 2'b00;
    while (O_done === 2'b00 && cyc < 30) begin
      step();
      cyc++;
    end
    vec++;
    if (O_error !== 2'b01 || O_done !== 2'b01 ||
        O_data_ready !== 2'b00 || O_data !== held) begin
      errs++;
      $display("FAIL tmo_abort got e=%b d=%b dr=%b data=%h want 01 01 00 %h",
               O_error, O_done, O_data_ready, O_data, held);
    end
    I_exec = 2'b10;
    step();
    vec++;
    if (O_grant !== 2'b10) begin
      errs++;
      $display("FAIL tmo_next_grant got %b want 10", O_grant);
    end
    I_exec         = 2'b00;
    MEM_data_in    = 16'h0F0F;
    MEM_data_ready = 1'b1;
    step();
    MEM_data_ready = 1'b0;
    vec++;
    if (O_done !== 2'b10 || O_error !== 2'b00 ||
        O_data !== 16'h0F0F) begin
      errs++;
      $display("FAIL tmo_next_done got d=%b e=%b data=%h want 10 00 0f0f",
               O_done, O_error, O_data);
    end
    step();
  endtask
`endif

  initial begin
    I_reset        = 1'b1;
    I_exec         = '0;
    I_write        = '0;
    I_addr         = '0;
    I_data         = '0;
    MEM_ready      = 1'b1;
    MEM_data_in    = '0;
    MEM_data_ready = 1'b0;
    test_reset();
    test_single_read();
    test_write_ch1();
    test_round_robin();
    test_mem_ready_low();
    test_reset_mid_read();
`ifdef MEM_ARB_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
